// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts a byte over valid/ready and sends start bit, DATA_BITS data bits
// LSB-first, then a stop bit on tx. Bit timing comes from an internal baud counter.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    // The stop bit hands over one cycle early so ready/done cover its final cycle,
    // letting a back-to-back start bit follow with no idle gap.
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= IDX_ZERO;
            shreg_q <= {DATA_BITS{1'b0}};
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Next-state, baud counting and serial line control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        ready_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                cnt_d   = CNT_ZERO;
                if (ready_q && tx_valid) begin
                    shreg_d = tx_data;
                    ready_d = 1'b0;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = CNT_ZERO;
                    idx_d   = IDX_ZERO;
                    tx_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
                        idx_d   = idx_q + IDX_ONE;
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (cnt_q == CNT_PRE) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = IDX_ZERO;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_ready = ready_q;
    assign tx       = tx_q;
    assign tx_done  = done_q;

endmodule
